// File: rtl/fwd_hazard_if.sv
// Bundle of ID-stage instruction metadata, pipeline controls and hazard-unit
// outputs shared between the pipeline control logic and fwd_hazard_unit.
interface fwd_hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              hold;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    // Pipeline side: presents the ID instruction and controls, consumes selects.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, hold, flush,
        input  fwd_a, fwd_b, stall, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, hold, flush,
        output fwd_a, fwd_b, stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for a 5-stage in-order pipeline.
// Tracks destination metadata through EX/MEM/WB, drives the two operand
// forwarding selects, raises a one-cycle load-use stall, and counts stalls.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  hz_io
);
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // EX stage metadata
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic              ex_valid_q, ex_valid_d;
    // MEM stage metadata
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_regwrite_q, mem_regwrite_d;
    logic              mem_valid_q, mem_valid_d;
    // WB stage metadata
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_valid_q, wb_valid_d;
    // Stall statistics
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic              stall_w;
    logic [1:0][REG_AW-1:0] ex_src;
    logic [1:0][1:0]        fwd_sel;

    assign ex_src[0] = ex_rs1_q;
    assign ex_src[1] = ex_rs2_q;

    // One select per ALU operand; MEM holds the newer value so it wins over WB.
    // Register 0 is never forwarded since it always reads as zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            assign mem_hit = mem_valid_q && mem_regwrite_q &&
                             (mem_rd_q == ex_src[gi]) && (ex_src[gi] != REG_ZERO);
            assign wb_hit  = wb_valid_q && wb_regwrite_q &&
                             (wb_rd_q == ex_src[gi]) && (ex_src[gi] != REG_ZERO);
            assign fwd_sel[gi] = !ex_valid_q ? 2'b00 :
                                 mem_hit     ? 2'b10 :
                                 wb_hit      ? 2'b01 : 2'b00;
        end
    endgenerate

    // A load in EX whose rd feeds the ID instruction cannot forward in time;
    // flush wins because the consumer is being squashed anyway.
    assign stall_w = hz_io.id_valid && !hz_io.flush && ex_valid_q && ex_memread_q &&
                     (ex_rd_q != REG_ZERO) &&
                     ((ex_rd_q == hz_io.id_rs1) || (ex_rd_q == hz_io.id_rs2));

    assign hz_io.fwd_a       = fwd_sel[0];
    assign hz_io.fwd_b       = fwd_sel[1];
    assign hz_io.stall       = stall_w;
    assign hz_io.stall_count = stall_count_q;

    // Next-state: advance the stage metadata unless frozen by hold.
    always_comb begin
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_memread_d   = ex_memread_q;
        ex_valid_d     = ex_valid_q;
        mem_rd_d       = mem_rd_q;
        mem_regwrite_d = mem_regwrite_q;
        mem_valid_d    = mem_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_valid_d     = wb_valid_q;
        stall_count_d  = stall_count_q;
        if (!hz_io.hold) begin
            wb_rd_d        = mem_rd_q;
            wb_regwrite_d  = mem_regwrite_q;
            wb_valid_d     = mem_valid_q;
            mem_rd_d       = ex_rd_q;
            mem_regwrite_d = ex_regwrite_q;
            mem_valid_d    = ex_valid_q;
            ex_rs1_d       = hz_io.id_rs1;
            ex_rs2_d       = hz_io.id_rs2;
            ex_rd_d        = hz_io.id_rd;
            ex_regwrite_d  = hz_io.id_regwrite;
            ex_memread_d   = hz_io.id_memread;
            // Squashed or stalled instructions enter EX as a bubble.
            ex_valid_d     = hz_io.id_valid && !hz_io.flush && !stall_w;
            if (stall_w && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_valid_q     <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            mem_valid_q    <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_valid_q     <= ex_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_valid_q    <= mem_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_valid_q     <= wb_valid_d;
            stall_count_q  <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand-written
// corner sequences (saturation, async reset) and a random run against a model.
module tb_fwd_hazard_unit;
    logic clk;
    logic rst_n;

    fwd_hazard_if #(.REG_AW(5), .CNT_W(16)) hif ();
    fwd_hazard_if #(.REG_AW(5), .CNT_W(2))  sif ();

    // The narrow-counter copy sees identical stimulus; it shows saturation quickly.
    assign sif.id_valid    = hif.id_valid;
    assign sif.id_rs1      = hif.id_rs1;
    assign sif.id_rs2      = hif.id_rs2;
    assign sif.id_rd       = hif.id_rd;
    assign sif.id_regwrite = hif.id_regwrite;
    assign sif.id_memread  = hif.id_memread;
    assign sif.hold        = hif.hold;
    assign sif.flush       = hif.flush;

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_io (hif)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_io (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit rw, input bit mr, input bit hold, input bit flush);
        hif.id_valid    = v;
        hif.id_rs1      = 5'(rs1);
        hif.id_rs2      = 5'(rs2);
        hif.id_rd       = 5'(rd);
        hif.id_regwrite = rw;
        hif.id_memread  = mr;
        hif.hold        = hold;
        hif.flush       = flush;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v; int rs1; int rs2; int rd; bit rw; bit mr; bit hold; bit flush;
        int ea; int eb; bit es; int ec;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit v, int rs1, int rs2, int rd, bit rw, bit mr,
                                bit hold, bit flush, int ea, int eb, bit es, int ec);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.mr = mr;
        r.hold = hold; r.flush = flush; r.ea = ea; r.eb = eb; r.es = es; r.ec = ec;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Each slot is one instruction in flight: index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct { bit v; bit rw; bit mr; int rs1; int rs2; int rd; } slot_t;
    slot_t pipe[3];
    int    m_cnt;

    function automatic bit produces(input slot_t s, input int r);
        return s.v && s.rw && (s.rd == r) && (r != 0);
    endfunction

    // Newest older instruction writing the source register supplies the value.
    function automatic int model_sel(input int r);
        if (!pipe[0].v) return 0;
        if (produces(pipe[1], r)) return 2;
        if (produces(pipe[2], r)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall(input bit v, input int rs1, input int rs2, input bit flush);
        return v && !flush && pipe[0].v && pipe[0].mr && (pipe[0].rd != 0) &&
               ((pipe[0].rd == rs1) || (pipe[0].rd == rs2));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 0};
        m_cnt = 0;
    endtask

    task automatic model_step(input slot_t id, input bit hold, input bit flush);
        bit s;
        s = model_stall(id.v, id.rs1, id.rs2, flush);
        if (!hold) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = id;
            pipe[0].v = id.v && !flush && !s;
            if (s && m_cnt < 65535) m_cnt++;
        end
    endtask

    initial begin
        int n_rand;
        int hz_base;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state (edges occur while reset is held).
        next_cycle();
        next_cycle();
        chk("reset.fwd_a", int'(hif.fwd_a), 0);
        chk("reset.fwd_b", int'(hif.fwd_b), 0);
        chk("reset.stall", int'(hif.stall), 0);
        chk("reset.count", int'(hif.stall_count), 0);
        rst_n = 1'b1;

        // v  rs1 rs2 rd rw mr hold flush | fwd_a fwd_b stall count
        vt.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));   // 0 ALU x5
        vt.push_back(mk(1, 5, 6, 8, 1, 0, 0, 0, 0, 0, 0, 0));   // 1 use x5
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));   // 2 consumer in EX: MEM fwd
        vt.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));   // 3 write x7
        vt.push_back(mk(1, 1, 2, 10, 1, 0, 0, 0, 0, 0, 0, 0));  // 4 unrelated
        vt.push_back(mk(1, 3, 7, 11, 1, 0, 0, 0, 0, 0, 0, 0));  // 5 consumer rs2=x7
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));   // 6 WB fwd on B
        vt.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));   // 7 write x7 (old)
        vt.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));   // 8 write x7 (new)
        vt.push_back(mk(1, 0, 7, 12, 1, 0, 0, 0, 0, 0, 0, 0));  // 9 consumer rs2=x7
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));   // 10 MEM beats WB
        vt.push_back(mk(1, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0));  // 11 rd=13, no regwrite
        vt.push_back(mk(1, 13, 13, 14, 1, 0, 0, 0, 0, 0, 0, 0));// 12 consumer of x13
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // 13 no fwd without regwrite
        vt.push_back(mk(1, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0));   // 14 load x9
        vt.push_back(mk(1, 9, 2, 15, 1, 0, 0, 0, 0, 0, 1, 0));  // 15 load-use: stall
        vt.push_back(mk(1, 9, 2, 15, 1, 0, 0, 0, 0, 0, 0, 1));  // 16 bubble in EX
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));   // 17 consumer gets WB
        vt.push_back(mk(1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1));   // 18 load x9
        vt.push_back(mk(1, 9, 0, 15, 1, 0, 0, 1, 0, 0, 0, 1));  // 19 flush kills stall
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));   // 20 EX bubble
        vt.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));   // 21 load x0
        vt.push_back(mk(1, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0, 1));  // 22 consumer x0: no stall
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));   // 23 no fwd of x0
        vt.push_back(mk(1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1));   // 24 load x9
        vt.push_back(mk(1, 1, 9, 17, 1, 0, 1, 0, 0, 0, 1, 1));  // 25 hold during stall
        vt.push_back(mk(1, 1, 9, 17, 1, 0, 1, 0, 0, 0, 1, 1));  // 26
        vt.push_back(mk(1, 1, 9, 17, 1, 0, 1, 0, 0, 0, 1, 1));  // 27
        vt.push_back(mk(1, 1, 9, 17, 1, 0, 0, 0, 0, 0, 1, 1));  // 28 release: counts once
        vt.push_back(mk(1, 1, 9, 17, 1, 0, 0, 0, 0, 0, 0, 2));  // 29 bubble
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2));   // 30 held, WB fwd on B
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));   // 31 still frozen state

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].rw, vt[i].mr,
                  vt[i].hold, vt[i].flush);
            #1;
            $display("vec %0d: fwd_a=%0d fwd_b=%0d stall=%0d count=%0d", i,
                     hif.fwd_a, hif.fwd_b, hif.stall, hif.stall_count);
            chk($sformatf("v%0d.fwd_a", i), int'(hif.fwd_a), vt[i].ea);
            chk($sformatf("v%0d.fwd_b", i), int'(hif.fwd_b), vt[i].eb);
            chk($sformatf("v%0d.stall", i), int'(hif.stall), int'(vt[i].es));
            chk($sformatf("v%0d.count", i), int'(hif.stall_count), vt[i].ec);
            chk($sformatf("v%0d.sat_count", i), int'(sif.stall_count), sat3(vt[i].ec));
            next_cycle();
        end

        // Saturation: three more load-use hazards; narrow counter pins at 3.
        hz_base = 2;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 9, 1, 1, 0, 0); next_cycle();
            drive(1, 9, 0, 20, 1, 0, 0, 0); #1;
            chk($sformatf("sat%0d.stall", k), int'(hif.stall), 1);
            next_cycle();
            drive(1, 9, 0, 20, 1, 0, 0, 0); #1;
            $display("sat %0d: count=%0d sat_count=%0d", k, hif.stall_count, sif.stall_count);
            chk($sformatf("sat%0d.count", k), int'(hif.stall_count), hz_base + k + 1);
            chk($sformatf("sat%0d.sat_count", k), int'(sif.stall_count), sat3(hz_base + k + 1));
            next_cycle();
        end

        // Asynchronous reset mid-cycle while forwarding and stall are both active.
        drive(1, 0, 0, 5, 1, 0, 0, 0); next_cycle();   // producer x5
        drive(1, 5, 0, 5, 1, 1, 0, 0); next_cycle();   // load x5 reading x5
        drive(1, 5, 0, 6, 1, 0, 0, 0); #1;             // consumer of the load
        chk("arst.pre_fwd_a", int'(hif.fwd_a), 2);
        chk("arst.pre_stall", int'(hif.stall), 1);
        #1 rst_n = 1'b0;
        #1;
        $display("async reset: fwd_a=%0d fwd_b=%0d stall=%0d count=%0d",
                 hif.fwd_a, hif.fwd_b, hif.stall, hif.stall_count);
        chk("arst.fwd_a", int'(hif.fwd_a), 0);
        chk("arst.fwd_b", int'(hif.fwd_b), 0);
        chk("arst.stall", int'(hif.stall), 0);
        chk("arst.count", int'(hif.stall_count), 0);
        chk("arst.sat_count", int'(sif.stall_count), 0);
        next_cycle();
        rst_n = 1'b1;
        drive(1, 5, 5, 0, 0, 0, 0, 0); #1;
        chk("post.stall", int'(hif.stall), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("post.fwd_a", int'(hif.fwd_a), 0);
        chk("post.fwd_b", int'(hif.fwd_b), 0);
        next_cycle();

        // Random run against the model, from a fresh reset.
        rst_n = 1'b0;
        #1;
        next_cycle();
        rst_n = 1'b1;
        model_reset();
        n_rand = 2000;
        for (int t = 0; t < n_rand; t++) begin
            slot_t id;
            bit    h;
            bit    f;
            int    ea;
            int    eb;
            bit    es;
            id.v   = ($urandom_range(0, 9) < 8);
            id.rs1 = $urandom_range(0, 3);
            id.rs2 = $urandom_range(0, 3);
            id.rd  = $urandom_range(0, 3);
            id.rw  = ($urandom_range(0, 9) < 7);
            id.mr  = ($urandom_range(0, 9) < 3);
            h      = ($urandom_range(0, 9) == 0);
            f      = ($urandom_range(0, 9) == 0);
            drive(id.v, id.rs1, id.rs2, id.rd, id.rw, id.mr, h, f);
            #1;
            ea = model_sel(pipe[0].rs1);
            eb = model_sel(pipe[0].rs2);
            es = model_stall(id.v, id.rs1, id.rs2, f);
            $display("rnd %0d: fwd_a=%0d/%0d fwd_b=%0d/%0d stall=%0d/%0d count=%0d/%0d", t,
                     hif.fwd_a, ea, hif.fwd_b, eb, hif.stall, es, hif.stall_count, m_cnt);
            chk($sformatf("r%0d.fwd_a", t), int'(hif.fwd_a), ea);
            chk($sformatf("r%0d.fwd_b", t), int'(hif.fwd_b), eb);
            chk($sformatf("r%0d.stall", t), int'(hif.stall), int'(es));
            chk($sformatf("r%0d.count", t), int'(hif.stall_count), m_cnt);
            chk($sformatf("r%0d.sat_count", t), int'(sif.stall_count), sat3(m_cnt));
            model_step(id, h, f);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
